// File: rtl/la_mpram_impl.sv
// ---------------------------------------------------------------------------
// la_mpram_impl
//
// Single-clock multi-port RAM: NP symmetric read/write ports sharing one
// storage array. Writes take per-bit masks; when several ports write the
// same word in one cycle, each bit goes to the lowest-index port that has
// that mask bit set, and every port that lost at least one masked bit
// raises collide for one cycle. Reads return either the pre-write contents
// (READ_FIRST) or the fully resolved post-write contents (WRITE_FIRST), and
// pass through a RLAT-cycle pipeline.
//
// Optional build macro:
//   LA_MPRAM_COLLCNT_EN - build the 16-bit saturating collision counter.
//                         When undefined coll_count is tied to zero.
//
// Ports:
//   clk        in   single clock for all ports
//   nreset     in   synchronous active-low reset
//   ce         in   [NP]     per-port chip enable
//   we         in   [NP]     per-port write enable (0 = read when ce)
//   wmask      in   [NP*DW]  per-bit write mask, port p at [p*DW +: DW]
//   addr       in   [NP*AW]  per-port address,  port p at [p*AW +: AW]
//   din        in   [NP*DW]  per-port write data
//   dout       out  [NP*DW]  per-port read data (held between reads)
//   dvalid     out  [NP]     one-cycle read-data-valid pulse
//   collide    out  [NP]     port lost a masked bit to a lower-index port
//   coll_count out  [16]     saturating count of collision cycles
//   vss/vdd/vddio, ctrl, test  in  unused pass-through pins
// ---------------------------------------------------------------------------
module la_mpram_impl #(
    parameter int    DW     = 32,
    parameter int    AW     = 10,
    parameter int    NP     = 2,
    parameter int    RLAT   = 1,
    parameter string WRMODE = "READ_FIRST",
    parameter string PROP   = "DEFAULT",
    parameter int    CTRLW  = 128,
    parameter int    TESTW  = 128
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [NP-1:0]    ce,
    input  logic [NP-1:0]    we,
    input  logic [NP*DW-1:0] wmask,
    input  logic [NP*AW-1:0] addr,
    input  logic [NP*DW-1:0] din,
    output logic [NP*DW-1:0] dout,
    output logic [NP-1:0]    dvalid,
    output logic [NP-1:0]    collide,
    output logic [15:0]      coll_count,
    input  logic             vss,
    input  logic             vdd,
    input  logic             vddio,
    input  logic [CTRLW-1:0] ctrl,
    input  logic [TESTW-1:0] test
);

    localparam int DEPTH       = 1 << AW;
    localparam bit WRITE_FIRST = (WRMODE == "WRITE_FIRST");
    localparam bit PROP_DFLT   = (PROP == "DEFAULT");

    // Reject unsupported configurations at elaboration.
    if (NP < 1 || NP > 8) begin : g_bad_np
        $error("la_mpram_impl: NP must be in 1..8");
    end
    if (RLAT < 1 || RLAT > 3) begin : g_bad_rlat
        $error("la_mpram_impl: RLAT must be in 1..3");
    end

    logic [DW-1:0]    ram_q [DEPTH];

    logic [NP-1:0]    wr_en;
    logic [NP-1:0]    rd_en;
    logic [AW-1:0]    port_addr [NP];
    logic [DW-1:0]    port_din  [NP];
    logic [DW-1:0]    port_mask [NP];
    logic [DW-1:0]    merged    [NP];
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]    collide_d;

    logic [NP-1:0]    in_vld;
    logic [NP*DW-1:0] in_dat;

    logic [NP*DW-1:0] dout_q;
    logic [NP-1:0]    dvalid_q;
    logic [NP-1:0]    collide_q;

    // Per-port unpacking; reset suppresses both writes and read issue.
    for (genvar gi = 0; gi < NP; gi++) begin : g_port
        assign port_addr[gi] = addr[gi*AW +: AW];
        assign port_din[gi]  = din[gi*DW +: DW];
        assign port_mask[gi] = wmask[gi*DW +: DW];
        assign wr_en[gi]     = nreset & ce[gi] & we[gi];
        assign rd_en[gi]     = nreset & ce[gi] & ~we[gi];
        assign rdata[gi*DW +: DW] = WRITE_FIRST ? merged[gi] : ram_q[port_addr[gi]];
    end

    // merged[p] is the word at port p's address after every write of this
    // cycle. Writes are layered from the highest index down so the lowest
    // index lands last and wins each contested bit. All writers of one
    // address compute the same merged word, so they can all store it.
    always_comb begin
        collide_d = '0;
        for (int p = 0; p < NP; p++) begin
            merged[p] = ram_q[port_addr[p]];
            for (int q = NP - 1; q >= 0; q--) begin
                if (wr_en[q] && (port_addr[q] == port_addr[p])) begin
                    merged[p] = (merged[p] & ~port_mask[q]) | (port_din[q] & port_mask[q]);
                end
            end
            for (int q = 0; q < p; q++) begin
                if (wr_en[p] && wr_en[q] && (port_addr[q] == port_addr[p]) &&
                    |(port_mask[q] & port_mask[p])) begin
                    collide_d[p] = 1'b1;
                end
            end
        end
    end

    // Storage is never reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (wr_en[p]) begin
                ram_q[port_addr[p]] <= merged[p];
            end
        end
    end

    // Read pipeline: RLAT-1 shift stages ahead of the output register.
    if (RLAT == 1) begin : g_lat1
        assign in_vld = rd_en;
        assign in_dat = rdata;
    end else begin : g_latn
        logic [NP-1:0]    pvld_q [RLAT-1];
        logic [NP*DW-1:0] pdat_q [RLAT-1];

        always_ff @(posedge clk) begin
            if (!nreset) begin
                for (int k = 0; k < RLAT - 1; k++) begin
                    pvld_q[k] <= '0;
                end
            end else begin
                pvld_q[0] <= rd_en;
                pdat_q[0] <= rdata;
                for (int k = 1; k < RLAT - 1; k++) begin
                    pvld_q[k] <= pvld_q[k-1];
                    pdat_q[k] <= pdat_q[k-1];
                end
            end
        end

        assign in_vld = pvld_q[RLAT-2];
        assign in_dat = pdat_q[RLAT-2];
    end

    // Output register: dout only moves on a valid read so it holds otherwise.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            dout_q    <= '0;
            dvalid_q  <= '0;
            collide_q <= '0;
        end else begin
            dvalid_q  <= in_vld;
            collide_q <= collide_d;
            for (int p = 0; p < NP; p++) begin
                if (in_vld[p]) begin
                    dout_q[p*DW +: DW] <= in_dat[p*DW +: DW];
                end
            end
        end
    end

    assign dout    = dout_q;
    assign dvalid  = dvalid_q;
    assign collide = collide_q;

`ifdef LA_MPRAM_COLLCNT_EN
    logic [15:0] coll_count_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            coll_count_q <= 16'h0;
        end else if (|collide_d && (coll_count_q != 16'hFFFF)) begin
            coll_count_q <= coll_count_q + 16'h1;
        end
    end

    assign coll_count = coll_count_q;
`else
    assign coll_count = 16'h0;
`endif

    // Power and test pins carry no function in the behavioural model.
    logic unused_pins;
    assign unused_pins = ^{vss, vdd, vddio, ctrl, test, PROP_DFLT};

endmodule

// File: tb/tb_la_mpram_impl.sv
// ---------------------------------------------------------------------------
// tb_la_mpram_impl
//
// Drives three copies of the RAM with identical stimulus:
//   d0: RLAT=1 READ_FIRST, d1: RLAT=1 WRITE_FIRST, d2: RLAT=3 READ_FIRST
// and compares every output each cycle against a word/bit-level reference
// model. Directed scenarios come first, then random traffic, then a long
// collision run to saturate the counter.
// ---------------------------------------------------------------------------
module tb_la_mpram_impl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NP = 2;
    localparam int ND = 3;

    logic             clk = 1'b0;
    logic             nreset;
    logic [NP-1:0]    ce;
    logic [NP-1:0]    we;
    logic [NP*DW-1:0] wmask;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] din;

    logic [NP*DW-1:0] dout_a    [ND];
    logic [NP-1:0]    dvalid_a  [ND];
    logic [NP-1:0]    collide_a [ND];
    logic [15:0]      cnt_a     [ND];

    always #5 clk = ~clk;

    la_mpram_impl #(.DW(DW), .AW(AW), .NP(NP), .RLAT(1), .WRMODE("READ_FIRST")) u_rf1 (
        .clk(clk), .nreset(nreset), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout_a[0]), .dvalid(dvalid_a[0]), .collide(collide_a[0]), .coll_count(cnt_a[0]),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(128'h0), .test(128'h0));

    la_mpram_impl #(.DW(DW), .AW(AW), .NP(NP), .RLAT(1), .WRMODE("WRITE_FIRST")) u_wf1 (
        .clk(clk), .nreset(nreset), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout_a[1]), .dvalid(dvalid_a[1]), .collide(collide_a[1]), .coll_count(cnt_a[1]),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(128'h0), .test(128'h0));

    la_mpram_impl #(.DW(DW), .AW(AW), .NP(NP), .RLAT(3), .WRMODE("READ_FIRST")) u_rf3 (
        .clk(clk), .nreset(nreset), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout_a[2]), .dvalid(dvalid_a[2]), .collide(collide_a[2]), .coll_count(cnt_a[2]),
        .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(128'h0), .test(128'h0));

    function automatic int lat_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic bit wf_of(input int d);
        return (d == 1);
    endfunction

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mem [16];
    logic [DW-1:0] m_dout [ND][NP];
    bit            m_dv   [ND][NP];
    bit            pv     [ND][4][NP];   // deliveries due, indexed by cycle mod 4
    logic [DW-1:0] pd     [ND][4][NP];
    logic [NP-1:0] m_coll;
    int            m_cnt;
    int            cyc = 0;
    bit            verbose = 1'b1;

    function automatic logic [15:0] exp_cnt();
`ifdef LA_MPRAM_COLLCNT_EN
        return m_cnt[15:0];
`else
        return 16'h0;
`endif
    endfunction

    // One clock: advance the model with the inputs presented at this edge,
    // then compare every output of every copy.
    task automatic step();
        logic [DW-1:0] nm [16];
        bit            wr [NP];
        bit            rd [NP];
        bit            lost;
        logic [AW-1:0] a;
        int            s;
        @(posedge clk);
        cyc++;
        if (!nreset) begin
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < NP; p++) begin
                    m_dout[d][p] = '0;
                    m_dv[d][p]   = 1'b0;
                    for (int k = 0; k < 4; k++) pv[d][k][p] = 1'b0;
                end
            m_coll = '0;
            m_cnt  = 0;
        end else begin
            nm     = mem;
            m_coll = '0;
            for (int p = 0; p < NP; p++) begin
                wr[p] = ce[p] & we[p];
                rd[p] = ce[p] & ~we[p];
            end
            // A bit written by port q sticks only if no lower port also wrote it.
            for (int q = 0; q < NP; q++) begin
                if (wr[q]) begin
                    a = addr[q*AW +: AW];
                    for (int i = 0; i < DW; i++) begin
                        if (wmask[q*DW + i]) begin
                            lost = 1'b0;
                            for (int p = 0; p < q; p++)
                                if (wr[p] && addr[p*AW +: AW] == a && wmask[p*DW + i]) lost = 1'b1;
                            if (lost) m_coll[q] = 1'b1;
                            else      nm[a][i] = din[q*DW + i];
                        end
                    end
                end
            end
            for (int d = 0; d < ND; d++)
                for (int p = 0; p < NP; p++)
                    if (rd[p]) begin
                        s = (cyc + lat_of(d) - 1) % 4;
                        pv[d][s][p] = 1'b1;
                        pd[d][s][p] = wf_of(d) ? nm[addr[p*AW +: AW]] : mem[addr[p*AW +: AW]];
                    end
            mem = nm;
            if (m_coll != 0 && m_cnt < 65535) m_cnt++;
            for (int d = 0; d < ND; d++) begin
                s = cyc % 4;
                for (int p = 0; p < NP; p++) begin
                    m_dv[d][p] = pv[d][s][p];
                    if (pv[d][s][p]) m_dout[d][p] = pd[d][s][p];
                    pv[d][s][p] = 1'b0;
                end
            end
        end
        #1;
        if (verbose)
            $display("cyc=%0d rst_n=%0b ce=%b we=%b addr=%h din=%h mask=%h | dv=%b/%b/%b coll=%b cnt=%h",
                     cyc, nreset, ce, we, addr, din, wmask, dvalid_a[0], dvalid_a[1], dvalid_a[2],
                     collide_a[0], cnt_a[0]);
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("c%0d_d%0d_dvalid%0d", cyc, d, p), 64'(dvalid_a[d][p]), 64'(m_dv[d][p]));
                chk($sformatf("c%0d_d%0d_dout%0d", cyc, d, p), 64'(dout_a[d][p*DW +: DW]), 64'(m_dout[d][p]));
            end
            chk($sformatf("c%0d_d%0d_collide", cyc, d), 64'(collide_a[d]), 64'(m_coll));
            chk($sformatf("c%0d_d%0d_coll_count", cyc, d), 64'(cnt_a[d]), 64'(exp_cnt()));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        ce = '0; we = '0; wmask = '0; addr = '0; din = '0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] m);
        ce[p] = 1'b1; we[p] = 1'b1;
        addr[p*AW +: AW] = a; din[p*DW +: DW] = d; wmask[p*DW +: DW] = m;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        ce[p] = 1'b1; we[p] = 1'b0; addr[p*AW +: AW] = a;
    endtask

    logic [DW-1:0] rmask;

    initial begin
        nreset = 1'b0;
        idle();
        step(); step();
        nreset = 1'b1;

        // Preload every word so reads never return unknown contents.
        for (int a = 0; a < 16; a += 2) begin
            idle();
            set_wr(0, 4'(a),     $urandom, 32'hFFFF_FFFF);
            set_wr(1, 4'(a + 1), $urandom, 32'hFFFF_FFFF);
            step();
        end

        // Write then read back on the other port.
        idle(); set_wr(0, 4'd3, 32'hDEADBEEF, 32'hFFFF_FFFF); step();
        idle(); set_rd(1, 4'd3); step();
        chk("wr_rd_rlat1_dout1", 64'(dout_a[0][63:32]), 64'h0000_0000_DEAD_BEEF);
        chk("wr_rd_rlat1_dvalid", 64'(dvalid_a[0]), 64'h2);
        idle(); step();
        chk("wr_rd_rlat1_pulse_end", 64'(dvalid_a[0]), 64'h0);
        step();
        chk("wr_rd_rlat3_dout1", 64'(dout_a[2][63:32]), 64'h0000_0000_DEAD_BEEF);
        step();

        // Partial mask write.
        idle(); set_wr(0, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
        idle(); set_wr(0, 4'd5, 32'h0000_0000, 32'h0000_FFFF); step();
        idle(); set_rd(1, 4'd5); step();
        chk("mask_dout1", 64'(dout_a[0][63:32]), 64'h0000_0000_FFFF_0000);
        idle(); step(); step();

        // Two-port collision on the same word.
        idle();
        set_wr(0, 4'd7, 32'h1111_1111, 32'hFFFF_FFFF);
        set_wr(1, 4'd7, 32'h2222_2222, 32'hFFFF_FFFF);
        step();
        chk("coll_bits", 64'(collide_a[0]), 64'h2);
`ifdef LA_MPRAM_COLLCNT_EN
        chk("coll_count_one", 64'(cnt_a[0]), 64'h1);
`else
        chk("coll_count_off", 64'(cnt_a[0]), 64'h0);
`endif
        idle(); set_rd(0, 4'd7); step();
        chk("coll_cleared", 64'(collide_a[0]), 64'h0);
        chk("coll_winner", 64'(dout_a[0][31:0]), 64'h0000_0000_1111_1111);
        idle(); step(); step();

        // Read during write on the same address.
        idle(); set_wr(0, 4'd2, 32'hA, 32'hFFFF_FFFF); step();
        idle(); set_wr(0, 4'd2, 32'hB, 32'hFFFF_FFFF); set_rd(1, 4'd2); step();
        chk("rdw_read_first", 64'(dout_a[0][63:32]), 64'hA);
        chk("rdw_write_first", 64'(dout_a[1][63:32]), 64'hB);
        idle(); step(); step();

        // Four back-to-back reads, then again with reset landing mid-pipeline.
        for (int i = 0; i < 4; i++) begin idle(); set_rd(1, 4'(i)); step(); end
        idle(); step(); step(); step();
        for (int i = 0; i < 4; i++) begin
            idle(); set_rd(1, 4'(8 + i));
            nreset = (i < 2);
            step();
        end
        idle(); nreset = 1'b1; set_rd(0, 4'd3); set_rd(1, 4'd5); step();
        idle(); step(); step(); step();

        // Random traffic over a narrow address range to provoke collisions.
        for (int n = 0; n < 2000; n++) begin
            idle();
            nreset = ($urandom_range(0, 63) != 0);
            for (int p = 0; p < NP; p++) begin
                ce[p] = ($urandom_range(0, 3) != 0);
                we[p] = $urandom_range(0, 1);
                addr[p*AW +: AW] = 4'($urandom_range(0, 3));
                din[p*DW +: DW] = $urandom;
                case ($urandom_range(0, 3))
                    0:       rmask = 32'hFFFF_FFFF;
                    1:       rmask = 32'h0;
                    default: rmask = $urandom;
                endcase
                wmask[p*DW +: DW] = rmask;
            end
            step();
        end
        nreset = 1'b1;

        // Long collision run to push the counter into saturation.
        $display("collision saturation run start cyc=%0d", cyc);
        verbose = 1'b0;
        idle();
        set_wr(0, 4'd9, 32'h5555_5555, 32'hFFFF_FFFF);
        set_wr(1, 4'd9, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
        for (int n = 0; n < 65540; n++) step();
        verbose = 1'b1;
        $display("collision saturation run end cyc=%0d cnt=%h", cyc, cnt_a[0]);
`ifdef LA_MPRAM_COLLCNT_EN
        chk("coll_count_saturated", 64'(cnt_a[0]), 64'hFFFF);
`else
        chk("coll_count_disabled", 64'(cnt_a[0]), 64'h0);
`endif
        idle(); nreset = 1'b0; step();
        chk("coll_count_reset", 64'(cnt_a[0]), 64'h0);
        nreset = 1'b1; step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/la_mpram_impl.md
# la_mpram_impl

Parametrised single-clock multi-port RAM: NP symmetric read/write ports over one storage array, with per-bit write masks, deterministic write-collision resolution, selectable read-during-write semantics and a configurable read pipeline (RLAT). It generalises the dual-port RAM wrapper for register-file and shared-buffer use inside lambda-based designs. It is the synthesizable behavioural model selected when PROP is "DEFAULT".

## Interface
- DW, 32, data width per port
- AW, 10, address width; depth 2**AW
- NP, 2, number of ports (1..8)
- RLAT, 1, read latency in cycles (1..3)
- WRMODE, "READ_FIRST", read-during-write semantics: "READ_FIRST" or "WRITE_FIRST"
- PROP, "DEFAULT", pass-through hard-macro selector
- CTRLW, 128, ctrl interface width
- TESTW, 128, test interface width

Ports:
- clk  in  1  single clock for all ports
- nreset  in  1  synchronous, active-low reset
- ce  in  NP  per-port chip enable
- we  in  NP  per-port write enable (1 = write, 0 = read when ce)
- wmask  in  NP*DW  per-bit write mask, port p at [p*DW +: DW]
- addr  in  NP*AW  per-port address, port p at [p*AW +: AW]
- din  in  NP*DW  per-port write data
- dout  out  NP*DW  per-port read data
- dvalid  out  NP  read-data-valid pulse per port
- collide  out  NP  port lost ≥1 masked bit to a lower-index port
- coll_count  out  16  saturating collision counter (LA_MPRAM_COLLCNT_EN only)
- vss, vdd, vddio  in  1  power pins, functionally unused
- ctrl  in  CTRLW, test  in  TESTW  pass-through, functionally unused

## Operation
- Issue cycle: a rising edge of clk with nreset=1. Write op = ce[p]&we[p]. Read op = ce[p]&~we[p].
- Write: bit i of ram[addr_p] takes din_p[i] only where wmask_p[i]=1.
- Same-address multi-write: per bit, the lowest-index port with its mask bit set wins. collide[q]=1 for each port q that had any masked bit overridden.
- Read, READ_FIRST: returns array contents from before the issue-cycle writes.
- Read, WRITE_FIRST: returns contents after all issue-cycle writes are applied, including collision resolution. Other ports' writes are forwarded.
- A port that is writing issues no read. Its dvalid stays 0.
- dout[p] holds its last value between valid reads.
- Array contents are not reset.
- Reset (nreset=0 at an edge):
  - dout=0, dvalid=0, collide=0, coll_count=0.
  - All in-flight pipeline reads are discarded.
  - Writes presented in that cycle are suppressed.
- Out-of-range NP or RLAT values fail elaboration.

## Timing
- Read issued at edge T: dout/dvalid are updated at edge T+RLAT-1 and visible during cycle T+RLAT-1..T+RLAT. For RLAT=1 they are visible the cycle after issue.
- dvalid is a single-cycle pulse per read. Back-to-back reads give one pulse per cycle, fully pipelined.
- A write at edge T is visible to any read issued at edge T+1 or later.
- collide is registered at the write edge and held for exactly one cycle.
- coll_count increments by 1 at each edge where any collide bit is set. It saturates at 0xFFFF.
- Reset asserted mid-pipeline: no dvalid appears from reads issued before or during reset. Reads issued at the first edge after deassertion are valid.

## Configuration
- LA_MPRAM_COLLCNT_EN defined: the coll_count register and its saturating increment logic are present.
- LA_MPRAM_COLLCNT_EN undefined: no counter register is built and coll_count is tied to 16'h0. The collide outputs are unaffected.

## Test plan
All scenarios use NP=2, DW=32, AW=4.
- RLAT=1: port0 writes 0xDEADBEEF to addr 3 with full mask; next cycle port1 reads addr 3 -> dout1=0xDEADBEEF with dvalid1 pulsing 1 cycle after issue.
- Mask test: preload addr 5 with 0xFFFFFFFF; port0 writes 0x00000000 with wmask 0x0000FFFF -> subsequent read returns 0xFFFF0000.
- Collision: port0 writes 0x11111111 and port1 writes 0x22222222 to addr 7 with full masks -> ram[7]=0x11111111, collide=2'b10 for one cycle, coll_count=1.
- Read-during-write on addr 2, preloaded 0xA, with port0 writing 0xB while port1 reads:
  - READ_FIRST -> dout1=0xA.
  - WRITE_FIRST -> dout1=0xB.
- RLAT=3: issue reads on 4 consecutive cycles -> 4 contiguous dvalid pulses starting at T+2. Assert nreset=0 after the second read -> no further dvalid, dout=0.
- Counter saturation: force 65540 collisions -> coll_count=0xFFFF. Without LA_MPRAM_COLLCNT_EN -> coll_count always 0.
